// File: rtl/fb_pkg.sv
// fb_pkg: shared colour constants, controller state encoding and sizing helper
// for the block-mode framebuffer.
package fb_pkg;

    localparam logic [7:0] BLK = 8'h00;
    localparam logic [7:0] WHT = 8'hff;
    localparam logic [7:0] RED = 8'he0;
    localparam logic [7:0] BLU = 8'h03;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

    function automatic int cell_count(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port RAM, one write port and one registered read port.
// Read-before-write: a same-cycle write to the read address returns old data.
module fb_ram #(
    parameter int DEPTH = 768,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/block_framebuffer.sv
// block_framebuffer: maps the VGA scan position onto a grid of SCALE x SCALE
// colour cells held in RAM, with a valid/ready write port and hardware clear.
module block_framebuffer
    import fb_pkg::*;
#(
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 24,
    parameter int SCALE   = 20,
    parameter int COLOR_W = 8,
    parameter int ADDR_W  = $clog2(cell_count(GRID_W, GRID_H))
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_pix_en,
    input  logic [9:0]         i_hc,
    input  logic [9:0]         i_vc,
    input  logic [COLOR_W-1:0] i_bg_color,
    output logic [COLOR_W-1:0] o_pix_color,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [COLOR_W-1:0] i_wr_data,
    output logic               o_wr_err,
    input  logic               i_clear_req,
    output logic               o_clear_busy
);

    localparam int CELLS = cell_count(GRID_W, GRID_H);
    localparam int CW    = $clog2(GRID_W + 1);
    localparam int RW    = $clog2(GRID_H + 1);
    localparam int SW    = $clog2(SCALE);

    logic [CW-1:0]      r_col, w_col;
    logic [RW-1:0]      r_row, w_row;
    logic [SW-1:0]      r_col_sub, w_col_sub, r_row_sub, w_row_sub;
    logic               w_col_wrap, w_row_wrap, w_line_start, w_in_grid;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic               r_in_grid_d;
    logic [COLOR_W-1:0] r_pix, w_ram_q;

    fb_state_e          r_state;
    logic [ADDR_W-1:0]  r_clr_idx;
    logic               r_busy, r_ready, r_wr_err;
    logic               w_clearing, w_wr_acc, w_oor, w_clr_last;

    // Next-state counters describe the position currently on hc/vc, so the
    // RAM address can be issued this tick and the colour lands two ticks later.
    assign w_line_start = (i_hc == '0);
    assign w_col_wrap   = (r_col_sub == SW'(SCALE - 1));
    assign w_row_wrap   = (r_row_sub == SW'(SCALE - 1));
    assign w_col_sub    = w_line_start ? '0 : w_col_wrap ? '0 : r_col_sub + 1'b1;
    assign w_col        = w_line_start ? '0 :
                          (w_col_wrap && r_col != CW'(GRID_W)) ? r_col + 1'b1 : r_col;
    assign w_row_sub    = !w_line_start ? r_row_sub : (i_vc == '0) ? '0 :
                          w_row_wrap ? '0 : r_row_sub + 1'b1;
    assign w_row        = !w_line_start ? r_row : (i_vc == '0) ? '0 :
                          (w_row_wrap && r_row != RW'(GRID_H)) ? r_row + 1'b1 : r_row;
    assign w_in_grid    = (r_col_lt(w_col)) && (w_row < RW'(GRID_H));
    assign w_rd_addr    = w_in_grid ? ADDR_W'(32'(w_row) * GRID_W + 32'(w_col)) : '0;

    function automatic logic r_col_lt(input logic [CW-1:0] c);
        return c < CW'(GRID_W);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_col_sub   <= '0;
            r_row       <= '0;
            r_row_sub   <= '0;
            r_in_grid_d <= 1'b0;
            r_pix       <= '0;
        end else if (i_pix_en) begin
            r_col       <= w_col;
            r_col_sub   <= w_col_sub;
            r_row       <= w_row;
            r_row_sub   <= w_row_sub;
            r_in_grid_d <= w_in_grid;
            r_pix       <= r_in_grid_d ? w_ram_q : i_bg_color;
        end
    end

    assign w_clearing = (r_state == CLEAR);
    assign w_clr_last = (r_clr_idx == ADDR_W'(CELLS - 1));
    assign w_oor      = (32'(i_wr_addr) >= CELLS);
    // clear_req in IDLE wins over a simultaneous write, so it also masks ready
    assign o_wr_ready = r_ready & ~i_clear_req;
    assign w_wr_acc   = i_wr_valid & o_wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
            r_wr_err  <= 1'b0;
        end else begin
            r_wr_err <= w_wr_acc & w_oor;
            if (r_state == CLEAR) begin
                r_clr_idx <= r_clr_idx + 1'b1;
                if (w_clr_last) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            end else if (i_clear_req) begin
                r_state   <= CLEAR;
                r_clr_idx <= '0;
                r_busy    <= 1'b1;
                r_ready   <= 1'b0;
            end
        end
    end

    fb_ram #(
        .DEPTH (CELLS),
        .WIDTH (COLOR_W),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_clearing | (w_wr_acc & ~w_oor)),
        .i_waddr (w_clearing ? r_clr_idx : i_wr_addr),
        .i_wdata (w_clearing ? i_bg_color : i_wr_data),
        .i_re    (i_pix_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_q)
    );

    assign o_pix_color  = r_pix;
    assign o_wr_err     = r_wr_err;
    assign o_clear_busy = r_busy;

endmodule

// File: tb/tb_block_framebuffer.sv
// tb_block_framebuffer: scoreboard bench for two framebuffer configurations
// (32x24 cells of 20 px, and 64x48 cells of 10 px) sharing scan inputs.
module tb_block_framebuffer;
    import fb_pkg::*;

    localparam int S1 = 20, W1 = 32, H1 = 24, N1 = 768;
    localparam int S2 = 10, W2 = 64, H2 = 48, N2 = 3072;

    logic clk = 1'b0, rst_n = 1'b1, pix_en = 1'b0;
    logic [9:0] hc = '0, vc = '0;
    logic [7:0] bg = BLK;
    logic       wv1 = 1'b0, clr1 = 1'b0, wv2 = 1'b0;
    logic [9:0] wa1 = '0;
    logic [11:0] wa2 = '0;
    logic [7:0] wd1 = '0, wd2 = '0;
    logic [7:0] pix1, pix2;
    logic       rdy1, err1, busy1, rdy2, err2, busy2;

    logic [7:0] m1 [N1];
    logic [7:0] m2 [N2];

    typedef struct {
        int h;
        int v;
        logic [7:0] c1;
        logic [7:0] c2;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    block_framebuffer u1 (
        .clk(clk), .rst_n(rst_n), .i_pix_en(pix_en), .i_hc(hc), .i_vc(vc),
        .i_bg_color(bg), .o_pix_color(pix1), .i_wr_valid(wv1), .o_wr_ready(rdy1),
        .i_wr_addr(wa1), .i_wr_data(wd1), .o_wr_err(err1),
        .i_clear_req(clr1), .o_clear_busy(busy1)
    );

    block_framebuffer #(.GRID_W(W2), .GRID_H(H2), .SCALE(S2)) u2 (
        .clk(clk), .rst_n(rst_n), .i_pix_en(pix_en), .i_hc(hc), .i_vc(vc),
        .i_bg_color(bg), .o_pix_color(pix2), .i_wr_valid(wv2), .o_wr_ready(rdy2),
        .i_wr_addr(wa2), .i_wr_data(wd2), .o_wr_err(err2),
        .i_clear_req(1'b0), .o_clear_busy(busy2)
    );

    function automatic logic [7:0] exp1(input int h, input int v);
        int c = h / S1, r = v / S1;
        return (c < W1 && r < H1) ? m1[r * W1 + c] : bg;
    endfunction

    function automatic logic [7:0] exp2(input int h, input int v);
        int c = h / S2, r = v / S2;
        return (c < W2 && r < H2) ? m2[r * W2 + c] : bg;
    endfunction

    // One pix_en tick; the output seen after it belongs to the previous tick.
    task automatic tick(input int h, input int v, input bit gap, input bit flush);
        exp_t e;
        if (!flush) begin
            e.h = h; e.v = v; e.c1 = exp1(h, v); e.c2 = exp2(h, v);
            sb.push_back(e);
        end
        hc = 10'(h); vc = 10'(v); pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        if (sb.size() == (flush ? 1 : 2)) begin
            e = sb.pop_front();
            checks += 2;
            if (pix1 !== e.c1) begin
                failures++;
                $display("FAIL pix1 hc=%0d vc=%0d got=%h exp=%h", e.h, e.v, pix1, e.c1);
            end
            if (pix2 !== e.c2) begin
                failures++;
                $display("FAIL pix2 hc=%0d vc=%0d got=%h exp=%h", e.h, e.v, pix2, e.c2);
            end
        end
        if (gap) begin
            hc = '0; vc = '0;
            @(posedge clk); #1;
        end
    endtask

    task automatic scan(input int vlo, input int vhi, input int hhi, input bit gap);
        for (int v = 0; v <= vhi; v++) begin
            tick(0, v, gap, 1'b0);
            if (v >= vlo)
                for (int h = 1; h <= hhi; h++) tick(h, v, gap, 1'b0);
        end
        tick(1, 0, gap, 1'b1);
    endtask

    task automatic wait_clear(input int stop_at, input int req_at,
                              output int n1, output int n2, output int bad);
        n1 = -1; n2 = -1; bad = 0;
        for (int n = 1; n <= N2 + 100; n++) begin
            @(posedge clk); #1;
            clr1 = 1'b0;
            if (busy1 && rdy1) bad++;
            if (n1 < 0 && !busy1) n1 = n;
            if (n2 < 0 && !busy2) n2 = n;
            if (n == req_at) clr1 = 1'b1;
            if (n == stop_at || (n1 >= 0 && n2 >= 0)) break;
        end
    endtask

    task automatic write1(input int a, input logic [7:0] d);
        int k = 0;
        while (!rdy1 && k < 5000) begin @(posedge clk); #1; k++; end
        checks++;
        if (rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL write1_ready got=%b exp=1", rdy1);
        end
        wv1 = 1'b1; wa1 = a[9:0]; wd1 = d;
        @(posedge clk); #1;
        wv1 = 1'b0;
        if (a < N1) m1[a] = d;
    endtask

    task automatic write2(input int a, input logic [7:0] d);
        int k = 0;
        while (!rdy2 && k < 5000) begin @(posedge clk); #1; k++; end
        checks++;
        if (rdy2 !== 1'b1) begin
            failures++;
            $display("FAIL write2_ready got=%b exp=1", rdy2);
        end
        wv2 = 1'b1; wa2 = a[11:0]; wd2 = d;
        @(posedge clk); #1;
        wv2 = 1'b0;
        if (a < N2) m2[a] = d;
    endtask

    task automatic check_reset_values(input string tag);
        checks += 5;
        if (pix1 !== 8'h00 || pix2 !== 8'h00) begin
            failures++;
            $display("FAIL %s_pix got=%h/%h exp=00/00", tag, pix1, pix2);
        end
        if (err1 !== 1'b0) begin failures++; $display("FAIL %s_err got=%b exp=0", tag, err1); end
        if (busy1 !== 1'b1) begin failures++; $display("FAIL %s_busy got=%b exp=1", tag, busy1); end
        if (rdy1 !== 1'b0) begin failures++; $display("FAIL %s_ready got=%b exp=0", tag, rdy1); end
        if (busy2 !== 1'b1) begin failures++; $display("FAIL %s_busy2 got=%b exp=1", tag, busy2); end
    endtask

    task automatic check_clear_len(input string tag, input int n1, input int e1,
                                   input int n2, input int e2, input int bad);
        checks += 4;
        if (n1 != e1) begin failures++; $display("FAIL %s_len1 got=%0d exp=%0d", tag, n1, e1); end
        if (n2 != e2) begin failures++; $display("FAIL %s_len2 got=%0d exp=%0d", tag, n2, e2); end
        if (bad != 0) begin failures++; $display("FAIL %s_ready_in_clear got=%0d exp=0", tag, bad); end
        if (rdy1 !== 1'b1) begin failures++; $display("FAIL %s_ready_after got=%b exp=1", tag, rdy1); end
    endtask

    task automatic test_reset;
        int n1, n2, bad;
        bg = WHT;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        bg = BLK;
        rst_n = 1'b1;
        wait_clear(-1, -1, n1, n2, bad);
        check_clear_len("reset_clear", n1, N1, n2, N2, bad);
        foreach (m1[i]) m1[i] = BLK;
        foreach (m2[i]) m2[i] = BLK;
        scan(0, 1, 799, 1'b0);
        scan(478, 481, 799, 1'b0);
    endtask

    task automatic test_write;
        write1(174, RED);
        checks++;
        if (err1 !== 1'b0) begin failures++; $display("FAIL write_err got=%b exp=0", err1); end
        scan(99, 121, 301, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [7:0] cols [4] = '{RED, BLU, WHT, RED};
        write1(0, cols[0]);
        wv1 = 1'b1;
        for (int i = 1; i < 4; i++) begin
            wa1 = 10'(i); wd1 = cols[i];
            checks++;
            if (rdy1 !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", rdy1); end
            @(posedge clk); #1;
            m1[i] = cols[i];
        end
        wv1 = 1'b0;
        scan(0, 21, 90, 1'b0);
    endtask

    task automatic test_edge;
        write1(767, BLU);
        write2(64, RED);
        bg = WHT;
        scan(477, 481, 799, 1'b1);
        scan(0, 21, 12, 1'b1);
    endtask

    task automatic test_oor;
        write1(768, RED);
        checks++;
        if (err1 !== 1'b1) begin failures++; $display("FAIL oor_err_pulse got=%b exp=1", err1); end
        @(posedge clk); #1;
        checks++;
        if (err1 !== 1'b0) begin failures++; $display("FAIL oor_err_clear got=%b exp=0", err1); end
        scan(0, 1, 45, 1'b0);
    endtask

    task automatic test_clear_contention;
        int n1, n2, bad;
        bg = RED;
        clr1 = 1'b1; wv1 = 1'b1; wa1 = 10'd5; wd1 = WHT;
        #1;
        checks++;
        if (rdy1 !== 1'b0) begin failures++; $display("FAIL contention_ready got=%b exp=0", rdy1); end
        @(posedge clk); #1;
        clr1 = 1'b0; wv1 = 1'b0;
        checks += 2;
        if (busy1 !== 1'b1) begin failures++; $display("FAIL contention_busy got=%b exp=1", busy1); end
        if (err1 !== 1'b0) begin failures++; $display("FAIL contention_err got=%b exp=0", err1); end
        wait_clear(-1, 300, n1, n2, bad);
        check_clear_len("contention", n1, N1, n2, 1, bad);
        foreach (m1[i]) m1[i] = RED;
        bg = WHT;
        scan(0, 1, 119, 1'b0);
        scan(478, 480, 660, 1'b0);
    endtask

    task automatic test_reset_mid_clear;
        int n1, n2, bad;
        bg = BLK;
        clr1 = 1'b1;
        @(posedge clk); #1;
        clr1 = 1'b0;
        wait_clear(300, -1, n1, n2, bad);
        rst_n = 1'b0;
        #1 check_reset_values("midclear");
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_clear(-1, -1, n1, n2, bad);
        check_clear_len("midclear_restart", n1, N1, n2, N2, bad);
        foreach (m1[i]) m1[i] = BLK;
        foreach (m2[i]) m2[i] = BLK;
        scan(0, 21, 30, 1'b0);
        bg = WHT;
        write2(64, RED);
        scan(0, 21, 12, 1'b0);
        scan(470, 481, 660, 1'b0);
    endtask

    initial begin
        test_reset;
        test_write;
        test_back_to_back;
        test_edge;
        test_oor;
        test_clear_contention;
        test_reset_mid_clear;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_framebuffer.md
# block_framebuffer

Writable, parametrised block-mode framebuffer for the VGA path. It maps the scan position (hc, vc) onto a GRID_W x GRID_H grid of colour cells, each SCALE x SCALE screen pixels, using divider-free counters. Colour comes from a dual-port RAM written through a valid/ready port. It sits between the VGA timing generator and the colour DAC pins, and replaces fixed ROM sprites with runtime-updatable content plus hardware clear.

## Interface
- GRID_W, 32, cells per row
- GRID_H, 24, cells per column
- SCALE, 20, screen pixels per cell edge (>= 2)
- COLOR_W, 8, colour width (RGB332 at default)
- ADDR_W, $clog2(GRID_W*GRID_H), cell address width (derived; not overridden)

- Clock and reset (already decided): one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- pix_en  in  1  pixel-rate enable; hc/vc advance only on cycles with pix_en=1
- hc  in  10  horizontal count, 0 at first active pixel
- vc  in  10  vertical count, 0 at first active line
- bg_color  in  COLOR_W  colour used outside the grid and by clear
- pix_color  out  COLOR_W  registered pixel colour
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  ADDR_W  cell index = row*GRID_W + col
- wr_data  in  COLOR_W  cell colour
- wr_err  out  1  one-cycle pulse: accepted write had wr_addr >= GRID_W*GRID_H
- clear_req  in  1  start fill of all cells with bg_color
- clear_busy  out  1  clear in progress

## Operation
- **Position counters.** They update only on pix_en.
  - On every pix_en, the horizontal counters (col, col_sub) reset to 0 if hc==0.
  - Otherwise col_sub increments. When col_sub wraps at SCALE-1, col increments; col saturates at GRID_W.
  - Vertical counters (row, row_sub) update only on pix_en with hc==0: reset to 0 if vc==0, else the same wrap/saturate rule against GRID_H.
- **In-grid test.** in_grid = (col < GRID_W) & (row < GRID_H). No division or multiplication by SCALE anywhere. The row*GRID_W product is a constant-multiply; it becomes a shift when GRID_W is a power of two.
- **Read pipeline.** It advances on pix_en.
  - S1 registers rd_addr = row*GRID_W + col and in_grid_d.
  - S2 is the synchronous RAM read plus the output register.
  - pix_color = in_grid_d2 ? ram_q : bg_color.
- **FSM states.** Encoding is in the package.
  - CLEAR: entered from reset and on clear_req in IDLE. Writes bg_color to cell clr_idx, clr_idx increments each clk, exits to IDLE after cell GRID_W*GRID_H-1. clear_busy=1, wr_ready=0.
  - IDLE: wr_ready=1. An accepted write with an in-range address writes the RAM. An out-of-range address is dropped and wr_err pulses the next cycle.
- **clear_req rules.**
  - In IDLE, clear_req takes priority over a simultaneous wr_valid; that write is not accepted.
  - clear_req while already in CLEAR is ignored; there is no restart.
- **Read/write collision.** A write to the same cell being read in the same clk gives old data on the read; the new value is visible from the next read.

## Timing
- Reset values: pix_color=0, wr_err=0.
- Reset leaves the FSM in CLEAR with clr_idx=0, so clear_busy=1 and wr_ready=0 immediately.
- The first clear completes GRID_W*GRID_H clk after rst_n deasserts; wr_ready rises on the following cycle.
- RAM contents are not reset; the auto-clear defines them.
- pix_color is valid 2 pix_en ticks after the hc/vc it belongs to. The timing generator delays hsync/vsync by 2 ticks.
- Clear duration is GRID_W*GRID_H clk cycles, independent of pix_en. The display shows partially cleared content during that time; this is accepted.
- rst_n assertion mid-clear or mid-write aborts immediately; a full auto-clear follows release.
- Boundary: at default parameters, hc=639 maps to col 31, hc=640 maps to outside the grid (bg), vc=479 maps to row 23.

## Structure
- Package fb_pkg holds:
  - colour constants BLK=8'h00, WHT=8'hff, RED=8'he0, BLU=8'h03;
  - the FSM state enum (IDLE, CLEAR);
  - a function for cell count.
- Sub-module fb_ram: simple dual-port RAM with one write port and one synchronous read port, parametrised depth/width, inferred as BRAM.

## Test plan
- **Reset auto-clear:** release rst_n with bg_color=BLK → clear_busy=1 for 768 clk, wr_ready=0 during it, then wr_ready=1; full-frame scan gives pix_color=8'h00 everywhere.
- **Single write and scan:** write addr 174 (row 5, col 14) = RED → pix_color=8'he0 for hc 280..299, vc 100..119, output 2 pix_en ticks after each position; neighbours (hc 279, hc 300) remain BLK.
- **Edge and out-of-grid:** write addr 767=BLU, bg_color=WHT → BLU at hc 639/vc 479; hc 640..799 gives WHT; with pix_en toggling every other clk, the counters advance only on pix_en.
- **Out-of-range write:** wr_addr 768 → accepted, wr_err=1 for exactly one cycle, no cell changes.
- **Clear contention:** assert clear_req and wr_valid in the same IDLE cycle → write not accepted, 768-cycle clear; clear_req again mid-clear → ignored, clear still ends at 768.
- **Reset mid-clear:** pulse rst_n low at clr_idx=300 → outputs return to reset values, clear restarts from 0. Repeat with SCALE=10, GRID_W=64, GRID_H=48: write addr 64 → cell spans hc 0..9, vc 10..19.
